// File: rtl/cpu_pkg.sv
// Shared constants for the multi-cycle CPU: opcodes, funct codes, ALU codes,
// datapath mux encodings and the controller state enum.
package cpu_pkg;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpAddi  = 6'b001000;

    localparam logic [5:0] FnAdd = 6'b100000;
    localparam logic [5:0] FnSub = 6'b100010;
    localparam logic [5:0] FnAnd = 6'b100100;
    localparam logic [5:0] FnOr  = 6'b100101;
    localparam logic [5:0] FnSlt = 6'b101010;
    localparam logic [5:0] FnNor = 6'b100111;

    localparam logic [3:0] AluAnd = 4'b0000;
    localparam logic [3:0] AluOr  = 4'b0001;
    localparam logic [3:0] AluAdd = 4'b0010;
    localparam logic [3:0] AluSub = 4'b0110;
    localparam logic [3:0] AluSlt = 4'b0111;
    localparam logic [3:0] AluNor = 4'b1100;

    localparam logic [1:0] SrcBReg    = 2'd0;
    localparam logic [1:0] SrcBFour   = 2'd1;
    localparam logic [1:0] SrcBImm    = 2'd2;
    localparam logic [1:0] SrcBImmSh2 = 2'd3;

    localparam logic [1:0] PcSrcAlu    = 2'd0;
    localparam logic [1:0] PcSrcAluOut = 2'd1;
    localparam logic [1:0] PcSrcJump   = 2'd2;

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAddr  = 4'd2,
        StMemRd    = 4'd3,
        StMemWb    = 4'd4,
        StMemWr    = 4'd5,
        StExec     = 4'd6,
        StRWb      = 4'd7,
        StBranch   = 4'd8,
        StJump     = 4'd9,
        StAddiExec = 4'd10,
        StAddiWb   = 4'd11
    } state_e;

endpackage

// File: rtl/multi_cycle_control_if.sv
// Controller <-> datapath signal bundle; master is the controller side.
interface multi_cycle_control_if;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       Zero;
    logic       mem_ready;
    logic       PCWrite;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] PCSource;
    logic [3:0] ALU_Control;
    logic       illegal;
    logic [3:0] state;

    modport master (
        input  opcode, funct, Zero, mem_ready,
        output PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               ALUSrcA, ALUSrcB, PCSource, ALU_Control, illegal, state
    );

    modport slave (
        output opcode, funct, Zero, mem_ready,
        input  PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               ALUSrcA, ALUSrcB, PCSource, ALU_Control, illegal, state
    );

endinterface

// File: rtl/alu_func_decode.sv
// R-type funct to ALU control code; unsupported funct yields AND with valid_o low.
module alu_func_decode
    import cpu_pkg::*;
(
    input  logic [5:0] funct_i,
    output logic [3:0] alu_control_o,
    output logic       valid_o
);

    always_comb begin
        valid_o       = 1'b1;
        alu_control_o = AluAnd;
        case (funct_i)
            FnAdd:   alu_control_o = AluAdd;
            FnSub:   alu_control_o = AluSub;
            FnAnd:   alu_control_o = AluAnd;
            FnOr:    alu_control_o = AluOr;
            FnSlt:   alu_control_o = AluSlt;
            FnNor:   alu_control_o = AluNor;
            default: valid_o       = 1'b0;
        endcase
    end

endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle MIPS-subset controller: sequences fetch/decode/execute/memory/write-back
// and decodes datapath selects and strobes from the current state.
module multi_cycle_control
    import cpu_pkg::*;
(
    input logic                   clk,
    input logic                   rst_n,
    multi_cycle_control_if.master bus
);

    state_e     state_q, state_d;
    logic       run_q;
    logic       illegal_q, illegal_d;
    logic       is_sw_q, is_sw_d;
    logic [3:0] funct_alu;
    logic       funct_valid;

    logic       pc_write, iord, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b, pc_source;
    logic [3:0] alu_control;

    alu_func_decode u_alu_func_decode (
        .funct_i       (bus.funct),
        .alu_control_o (funct_alu),
        .valid_o       (funct_valid)
    );

    always_comb begin
        state_d     = state_q;
        illegal_d   = illegal_q;
        is_sw_d     = is_sw_q;
        pc_write    = 1'b0;
        iord        = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = SrcBReg;
        pc_source   = PcSrcAlu;
        alu_control = AluAdd;

        case (state_q)
            StFetch: begin
                mem_read  = 1'b1;
                alu_src_b = SrcBFour;
                if (bus.mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = StDecode;
                end
            end
            StDecode: begin
                alu_src_b = SrcBImmSh2;
                case (bus.opcode)
                    OpLw: begin
                        is_sw_d = 1'b0;
                        state_d = StMemAddr;
                    end
                    OpSw: begin
                        is_sw_d = 1'b1;
                        state_d = StMemAddr;
                    end
                    OpRtype: state_d = StExec;
                    OpBeq:   state_d = StBranch;
                    OpJ:     state_d = StJump;
                    OpAddi:  state_d = StAddiExec;
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = StFetch;
                    end
                endcase
            end
            StMemAddr: begin
                alu_src_a = 1'b1;
                alu_src_b = SrcBImm;
                state_d   = is_sw_q ? StMemWr : StMemRd;
            end
            StMemRd: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (bus.mem_ready) state_d = StMemWb;
            end
            StMemWb: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = StFetch;
            end
            StMemWr: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (bus.mem_ready) state_d = StFetch;
            end
            StExec: begin
                alu_src_a   = 1'b1;
                alu_control = funct_alu;
                if (funct_valid) begin
                    state_d = StRWb;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = StFetch;
                end
            end
            StRWb: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_d   = StFetch;
            end
            StBranch: begin
                alu_src_a   = 1'b1;
                alu_control = AluSub;
                pc_source   = PcSrcAluOut;
                pc_write    = bus.Zero;
                state_d     = StFetch;
            end
            StJump: begin
                pc_source = PcSrcJump;
                pc_write  = 1'b1;
                state_d   = StFetch;
            end
            StAddiExec: begin
                alu_src_a = 1'b1;
                alu_src_b = SrcBImm;
                state_d   = StAddiWb;
            end
            StAddiWb: begin
                reg_write = 1'b1;
                state_d   = StFetch;
            end
            default: state_d = StFetch;
        endcase

        // Hold in FETCH until the cycle after reset release.
        if (!run_q) state_d = StFetch;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StFetch;
            run_q     <= 1'b0;
            illegal_q <= 1'b0;
            is_sw_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_q     <= 1'b1;
            illegal_q <= illegal_d;
            is_sw_q   <= is_sw_d;
        end
    end

    // run_q clears asynchronously, so strobes drop the moment reset asserts.
    assign bus.PCWrite     = pc_write & run_q;
    assign bus.MemRead     = mem_read & run_q;
    assign bus.MemWrite    = mem_write & run_q;
    assign bus.IRWrite     = ir_write & run_q;
    assign bus.RegWrite    = reg_write & run_q;
    assign bus.IorD        = iord;
    assign bus.RegDst      = reg_dst;
    assign bus.MemtoReg    = mem_to_reg;
    assign bus.ALUSrcA     = alu_src_a;
    assign bus.ALUSrcB     = alu_src_b;
    assign bus.PCSource    = pc_source;
    assign bus.ALU_Control = alu_control;
    assign bus.illegal     = illegal_q;
    assign bus.state       = state_q;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Bench for multi_cycle_control: per-instruction expected cycle traces built from the
// instruction semantics, compared every cycle, plus literal pins on key cycles.
module tb_multi_cycle_control;

    localparam logic [3:0] SFetch = 4'd0, SDecode = 4'd1, SMemAddr = 4'd2, SMemRd = 4'd3;
    localparam logic [3:0] SMemWb = 4'd4, SMemWr = 4'd5, SExec = 4'd6, SRWb = 4'd7;
    localparam logic [3:0] SBranch = 4'd8, SJump = 4'd9, SAddiEx = 4'd10, SAddiWb = 4'd11;
    localparam logic [3:0] Add4 = 4'b0010, Sub4 = 4'b0110;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, iord, mrd, mwr, irw, regdst, m2r, rw, srca;
        logic [1:0] srcb, pcsrc;
        logic [3:0] alu;
        logic       ill;
    } obs_t;

    logic  clk = 1'b0;
    logic  rst_n = 1'b0;
    int    checks = 0;
    int    errors = 0;
    logic  ill_m = 1'b0;
    logic  exp_on = 1'b0;
    obs_t  exp_r;
    obs_t  act;
    string exp_nm = "";
    obs_t  hist[$];

    multi_cycle_control_if ifc ();

    multi_cycle_control dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.master)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (exp_on) begin
            act = '{st: ifc.state, pcw: ifc.PCWrite, iord: ifc.IorD, mrd: ifc.MemRead,
                    mwr: ifc.MemWrite, irw: ifc.IRWrite, regdst: ifc.RegDst,
                    m2r: ifc.MemtoReg, rw: ifc.RegWrite, srca: ifc.ALUSrcA,
                    srcb: ifc.ALUSrcB, pcsrc: ifc.PCSource, alu: ifc.ALU_Control,
                    ill: ifc.illegal};
            hist.push_back(act);
            checks++;
            if (act !== exp_r) begin
                errors++;
                $display("FAIL %s: dut %h expected %h", exp_nm, act, exp_r);
            end
        end
    end

    task automatic pin(input string nm, input logic [3:0] got, input logic [3:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: dut %h expected %h", nm, got, want);
        end
    endtask

    function automatic obs_t base(input logic [3:0] st);
        obs_t o;
        o     = '0;
        o.st  = st;
        o.alu = Add4;
        o.ill = ill_m;
        return o;
    endfunction

    // {valid, ALU code}
    function automatic logic [4:0] alu_of(input logic [5:0] fn);
        case (fn)
            6'b100000: return {1'b1, 4'b0010};
            6'b100010: return {1'b1, 4'b0110};
            6'b100100: return {1'b1, 4'b0000};
            6'b100101: return {1'b1, 4'b0001};
            6'b101010: return {1'b1, 4'b0111};
            6'b100111: return {1'b1, 4'b1100};
            default:   return {1'b0, 4'b0000};
        endcase
    endfunction

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic cycle(input string nm, input logic rdy, input obs_t e);
        ifc.mem_ready = rdy;
        exp_r  = e;
        exp_nm = nm;
        exp_on = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_tail();
        obs_t e;
        ill_m = 1'b0;
        rst_n = 1'b0;
        e = base(SFetch);
        e.srcb = 2'd1;
        cycle("rst", rnd(), e);
        cycle("rst", rnd(), e);
        hist.delete();
        rst_n = 1'b1;
        cycle("rst_release", 1'b1, e);
    endtask

    task automatic instr(input string nm, input logic [5:0] op, input logic [5:0] fn,
                         input logic z, input int fw, input int mw);
        obs_t       e;
        logic [4:0] af;
        ifc.opcode = op;
        ifc.funct  = fn;
        ifc.Zero   = z;
        hist.delete();
        for (int i = 0; i <= fw; i++) begin
            e = base(SFetch);
            e.srcb = 2'd1;
            e.mrd  = 1'b1;
            e.irw  = (i == fw);
            e.pcw  = (i == fw);
            cycle({nm, "_fetch"}, i == fw, e);
        end
        e = base(SDecode);
        e.srcb = 2'd3;
        cycle({nm, "_decode"}, rnd(), e);
        case (op)
            6'b100011, 6'b101011: begin
                e = base(SMemAddr);
                e.srca = 1'b1;
                e.srcb = 2'd2;
                cycle({nm, "_memaddr"}, rnd(), e);
                for (int i = 0; i <= mw; i++) begin
                    e = base(op == 6'b100011 ? SMemRd : SMemWr);
                    e.iord = 1'b1;
                    if (op == 6'b100011) e.mrd = 1'b1;
                    else e.mwr = 1'b1;
                    cycle({nm, "_mem"}, i == mw, e);
                end
                if (op == 6'b100011) begin
                    e = base(SMemWb);
                    e.rw  = 1'b1;
                    e.m2r = 1'b1;
                    cycle({nm, "_memwb"}, rnd(), e);
                end
            end
            6'b000000: begin
                af = alu_of(fn);
                e = base(SExec);
                e.srca = 1'b1;
                e.alu  = af[3:0];
                cycle({nm, "_exec"}, rnd(), e);
                if (af[4]) begin
                    e = base(SRWb);
                    e.rw     = 1'b1;
                    e.regdst = 1'b1;
                    cycle({nm, "_rwb"}, rnd(), e);
                end else begin
                    ill_m = 1'b1;
                end
            end
            6'b000100: begin
                e = base(SBranch);
                e.srca  = 1'b1;
                e.alu   = Sub4;
                e.pcsrc = 2'd1;
                e.pcw   = z;
                cycle({nm, "_branch"}, rnd(), e);
            end
            6'b000010: begin
                e = base(SJump);
                e.pcsrc = 2'd2;
                e.pcw   = 1'b1;
                cycle({nm, "_jump"}, rnd(), e);
            end
            6'b001000: begin
                e = base(SAddiEx);
                e.srca = 1'b1;
                e.srcb = 2'd2;
                cycle({nm, "_addiex"}, rnd(), e);
                e = base(SAddiWb);
                e.rw = 1'b1;
                cycle({nm, "_addiwb"}, rnd(), e);
            end
            default: ill_m = 1'b1;
        endcase
    endtask

    initial begin
        ifc.opcode    = '0;
        ifc.funct     = '0;
        ifc.Zero      = 1'b0;
        ifc.mem_ready = 1'b0;
        @(posedge clk);
        #1;
        reset_tail();
        pin("rel_irw", 4'(hist[0].irw), 4'd0);
        pin("rel_mrd", 4'(hist[0].mrd), 4'd0);

        instr("lw", 6'b100011, 6'h00, 1'b0, 0, 0);
        pin("first_irw", 4'(hist[0].irw), 4'd1);
        pin("fetch_alu", hist[0].alu, 4'b0010);
        instr("sw", 6'b101011, 6'h00, 1'b0, 0, 0);
        instr("sub", 6'b000000, 6'b100010, 1'b0, 0, 0);
        pin("sub_alu", hist[2].alu, 4'b0110);
        pin("sub_rw", 4'(hist[3].rw), 4'd1);
        pin("sub_regdst", 4'(hist[3].regdst), 4'd1);
        instr("add", 6'b000000, 6'b100000, 1'b0, 0, 0);
        instr("and", 6'b000000, 6'b100100, 1'b0, 0, 0);
        instr("or", 6'b000000, 6'b100101, 1'b0, 0, 0);
        instr("slt", 6'b000000, 6'b101010, 1'b0, 0, 0);
        instr("nor", 6'b000000, 6'b100111, 1'b0, 0, 0);
        instr("addi", 6'b001000, 6'h00, 1'b0, 0, 0);
        instr("beq_t", 6'b000100, 6'h00, 1'b1, 0, 0);
        pin("beq_t_pcw", 4'(hist[2].pcw), 4'd1);
        pin("beq_t_pcsrc", 4'(hist[2].pcsrc), 4'd1);
        instr("beq_n", 6'b000100, 6'h00, 1'b0, 0, 0);
        pin("beq_n_pcw", 4'(hist[2].pcw), 4'd0);
        instr("j", 6'b000010, 6'h00, 1'b0, 0, 0);
        instr("lw_w2", 6'b100011, 6'h00, 1'b0, 0, 2);
        pin("lw_w2_hold", 4'({hist[4].mrd, hist[4].iord}), 4'd3);
        pin("lw_w2_memwb", hist[6].st, 4'd4);
        instr("lw_fw1", 6'b100011, 6'h00, 1'b0, 1, 0);
        instr("sw_w1", 6'b101011, 6'h00, 1'b0, 0, 1);

        instr("bad_op", 6'b111111, 6'h00, 1'b0, 0, 0);
        pin("bad_op_last", hist[hist.size() - 1].st, 4'd1);
        instr("add_after", 6'b000000, 6'b100000, 1'b0, 0, 0);
        pin("bad_op_next", hist[0].st, 4'd0);
        pin("bad_op_ill", 4'(hist[0].ill), 4'd1);
        instr("bad_fn", 6'b000000, 6'b000000, 1'b0, 0, 0);
        pin("bad_fn_alu", hist[2].alu, 4'b0000);
        instr("addi2", 6'b001000, 6'h00, 1'b0, 0, 0);
        pin("bad_fn_next", hist[0].st, 4'd0);

        // Abort a store that is waiting on memory.
        instr("sw_abort", 6'b101011, 6'h00, 1'b0, 0, 0);
        ifc.mem_ready = 1'b0;
        hist.delete();
        begin
            obs_t e;
            e = base(SFetch);
            e.srcb = 2'd1;
            e.mrd  = 1'b1;
            e.irw  = 1'b1;
            e.pcw  = 1'b1;
            ifc.opcode = 6'b101011;
            cycle("ab_fetch", 1'b1, e);
            e = base(SDecode);
            e.srcb = 2'd3;
            cycle("ab_decode", 1'b0, e);
            e = base(SMemAddr);
            e.srca = 1'b1;
            e.srcb = 2'd2;
            cycle("ab_memaddr", 1'b0, e);
            e = base(SMemWr);
            e.mwr  = 1'b1;
            e.iord = 1'b1;
            cycle("ab_memwr", 1'b0, e);
        end
        exp_on = 1'b0;
        #1;
        pin("ab_mwr_before", 4'(ifc.MemWrite), 4'd1);
        #1;
        rst_n = 1'b0;
        #1;
        pin("ab_mwr_drop", 4'(ifc.MemWrite), 4'd0);
        pin("ab_state", ifc.state, 4'd0);
        pin("ab_mrd", 4'(ifc.MemRead), 4'd0);
        @(posedge clk);
        #1;
        reset_tail();
        pin("ab_rel_strobes", 4'({hist[0].mrd, hist[0].irw, hist[0].pcw}), 4'd0);
        instr("add_post", 6'b000000, 6'b100000, 1'b0, 0, 0);
        pin("post_ill", 4'(hist[0].ill), 4'd0);
        pin("post_rw", 4'(hist[3].rw), 4'd1);

        exp_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_cycle_control.md
# multi_cycle_control

Multi-cycle datapath controller: sequences each MIPS-subset instruction through fetch/decode/execute/memory/write-back states. It drives the datapath mux selects, register/memory strobes and the 4-bit `ALU_Control` code consumed by the ALU. It sits between instruction register/memory and the shared single ALU of the multi-cycle CPU. Memory accesses use a ready handshake, so wait states stretch the sequence.

## Interface
- No parameters; opcode, funct and ALU codes are fixed constants in the shared package.
- `clk` in 1 — single clock; all state changes on the rising edge.
- `rst_n` in 1 — asynchronous, active-low reset.
- `opcode` in 6 — IR[31:26]; sampled in DECODE.
- `funct` in 6 — IR[5:0]; used in EXEC.
- `Zero` in 1 — ALU zero flag; used in BRANCH.
- `mem_ready` in 1 — memory completes the current access this cycle.
- `PCWrite` out 1 — PC load enable; includes the taken-branch term.
- `IorD` out 1 — memory address select: 0 = PC, 1 = ALUOut.
- `MemRead`, `MemWrite` out 1 each — memory strobes, held until `mem_ready`.
- `IRWrite` out 1 — instruction register load.
- `RegDst` out 1 — destination register: 0 = rt, 1 = rd.
- `MemtoReg` out 1 — write-back source: 0 = ALUOut, 1 = MDR.
- `RegWrite` out 1 — register file write.
- `ALUSrcA` out 1 — 0 = PC, 1 = A.
- `ALUSrcB` out 2 — 0 = B, 1 = const 4, 2 = sign-extended imm, 3 = sign-extended imm << 2.
- `PCSource` out 2 — 0 = ALU result, 1 = ALUOut, 2 = jump target.
- `ALU_Control` out 4 — AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100.
- `illegal` out 1 — sticky flag for an unsupported opcode or funct; cleared only by reset.
- `state` out 4 — current state, for debug.

## Operation
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000.
- Supported R-type funct: add 100000, sub 100010, and 100100, or 100101, slt 101010, nor 100111.
- States (encodings 0–11): FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC, R_WB, BRANCH, JUMP, ADDI_EXEC, ADDI_WB.
- FETCH:
  - Drives MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ADD, PCSource=0.
  - On `mem_ready`: IRWrite=1 and PCWrite=1, then go to DECODE. Otherwise stay in FETCH.
- DECODE: ALUSrcA=0, ALUSrcB=3, ADD (branch target into ALUOut). Branch on `opcode`:
  - lw/sw → MEM_ADDR
  - R-type → EXEC
  - beq → BRANCH
  - j → JUMP
  - addi → ADDI_EXEC
  - anything else → set `illegal`, go to FETCH
- MEM_ADDR: ALUSrcA=1, ALUSrcB=2, ADD. Go to MEM_RD for lw, MEM_WR for sw.
- MEM_RD: MemRead=1, IorD=1. Go to MEM_WB on `mem_ready`, else hold.
- MEM_WB: RegWrite=1, RegDst=0, MemtoReg=1. Go to FETCH.
- MEM_WR: MemWrite=1, IorD=1. Go to FETCH on `mem_ready`, else hold.
- EXEC: ALUSrcA=1, ALUSrcB=0, `ALU_Control` decoded from `funct`.
  - Unsupported funct: drive AND, set `illegal`, go to FETCH (skip R_WB).
  - Otherwise go to R_WB.
- R_WB: RegWrite=1, RegDst=1, MemtoReg=0. Go to FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=0, SUB, PCSource=1. PCWrite = `Zero`. Go to FETCH.
- JUMP: PCSource=2, PCWrite=1. Go to FETCH.
- ADDI_EXEC: ALUSrcA=1, ALUSrcB=2, ADD. Go to ADDI_WB.
- ADDI_WB: RegWrite=1, RegDst=0, MemtoReg=0. Go to FETCH.
- Any unlisted output is 0, and `ALU_Control` defaults to ADD.
- Unused state encodings 12–15 recover to FETCH on the next edge with no strobes asserted.

## Timing
- Outputs are Moore-decoded from `state`. Exceptions: `ALU_Control` in EXEC (depends on `funct`); IRWrite/PCWrite in FETCH and PCWrite in BRANCH (depend on `mem_ready`/`Zero`).
- Reset:
  - While `rst_n`=0: state = FETCH, `illegal`=0, and a `run` flag = 0.
  - `run` gates every strobe (MemRead, MemWrite, IRWrite, PCWrite, RegWrite) to 0.
  - `run` sets on the first rising edge after `rst_n` deasserts, so the first fetch starts one cycle later.
- CPI with zero-wait memory: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3. Each `mem_ready`-low cycle in FETCH, MEM_RD or MEM_WR adds exactly one cycle.
- `mem_ready` is ignored in states with no memory strobe.
- Reset asserted mid-instruction aborts immediately. No partial register or memory write may occur after `rst_n` falls.

## Structure
- Shared package `cpu_pkg` holds: opcode and funct constants, `ALU_Control` codes (shared with the ALU), ALUSrcB/PCSource encodings, and the state enum.
- Optional sub-module `alu_func_decode`: combinational `funct` → {`ALU_Control`, valid}.

## Test plan
- Reset, then `mem_ready`=1: first IRWrite exactly 2 cycles after `rst_n` rises; `ALU_Control`=0010 in FETCH.
- R-type sub (funct 100010): EXEC drives 0110; R_WB drives RegWrite=1, RegDst=1; total 4 cycles.
- lw with `mem_ready` low 2 cycles in MEM_RD: MemRead and IorD held; MEM_WB reached after 7 cycles total.
- beq with `Zero`=1, then `Zero`=0: PCWrite=1 with PCSource=1 in BRANCH, then PCWrite=0; 3 cycles each.
- Opcode 111111, and R-type funct 000000: `illegal`=1, no RegWrite, next state FETCH.
- Reset pulsed during MEM_WR: MemWrite drops the same cycle; state=FETCH; no strobes until `run` sets.
